gpr_seq_ctrl: RTL

- Command-driven sequencer for the 4-bit general-purpose shift register (gpr).
- Accepts one command at a time over a valid/ready handshake: load, clear, or a multi-cycle shift/rotate of programmable amount.
- Drives the register's sel/d/l_in/r_in each cycle and reads the register's q back for rotate/arithmetic fill.
- Sits between a command source (test harness or future microsequencer) and one gpr instance. clk and clr are shared with that instance.

---
 rtl/gpr_seq_ctrl.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/gpr_seq_ctrl.sv
// Command sequencer for the general-purpose shift register: accepts one
// load/clear/shift/rotate command at a time and drives the register's controls.
module gpr_seq_ctrl #(
  parameter int WIDTH = 4,
  parameter int AMT_W = 3
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [AMT_W-1:0] cmd_amt,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [WIDTH-1:0] gpr_q,
  output logic [1:0]       gpr_sel,
  output logic [WIDTH-1:0] gpr_d,
  output logic             gpr_l_in,
  output logic             gpr_r_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [2:0] OP_LOAD = 3'd0;
  localparam logic [2:0] OP_SHR  = 3'd1;
  localparam logic [2:0] OP_SHL  = 3'd2;
  localparam logic [2:0] OP_ROR  = 3'd3;
  localparam logic [2:0] OP_ROL  = 3'd4;
  localparam logic [2:0] OP_ASR  = 3'd5;
  localparam logic [2:0] OP_CLR  = 3'd6;

  localparam logic [1:0] SEL_HOLD  = 2'b00;
  localparam logic [1:0] SEL_RIGHT = 2'b01;
  localparam logic [1:0] SEL_LEFT  = 2'b10;
  localparam logic [1:0] SEL_LOAD  = 2'b11;

  localparam logic [AMT_W-1:0] CNT_ZERO = {AMT_W{1'b0}};
  localparam logic [AMT_W-1:0] CNT_ONE  = {{(AMT_W-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] DATA_ZERO = {WIDTH{1'b0}};

  state_t           state_q;
  logic [2:0]       op_q;
  logic [AMT_W-1:0] cnt_q;
  logic [1:0]       sel_q;
  logic [WIDTH-1:0] d_q;
  logic             done_q;
  logic [WIDTH-1:0] result_q;
  logic             l_in_s;
  logic             r_in_s;

  // Sequencer state, latched command, counter and registered register controls.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q  <= S_IDLE;
      op_q     <= 3'd0;
      cnt_q    <= CNT_ZERO;
      sel_q    <= SEL_HOLD;
      d_q      <= DATA_ZERO;
      done_q   <= 1'b0;
      result_q <= DATA_ZERO;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            op_q  <= cmd_op;
            cnt_q <= cmd_amt;
            case (cmd_op)
              OP_LOAD: begin
                state_q <= S_LOAD;
                sel_q   <= SEL_LOAD;
                d_q     <= cmd_data;
              end
              OP_CLR: begin
                state_q <= S_LOAD;
                sel_q   <= SEL_LOAD;
                d_q     <= DATA_ZERO;
              end
              OP_SHR, OP_ROR, OP_ASR: begin
                if (cmd_amt != CNT_ZERO) begin
                  state_q <= S_SHIFT;
                  sel_q   <= SEL_RIGHT;
                end else begin
                  state_q <= S_DONE;
                  done_q  <= 1'b1;
                end
              end
              OP_SHL, OP_ROL: begin
                if (cmd_amt != CNT_ZERO) begin
                  state_q <= S_SHIFT;
                  sel_q   <= SEL_LEFT;
                end else begin
                  state_q <= S_DONE;
                  done_q  <= 1'b1;
                end
              end
              default: begin
                // Reserved opcode: no register activity, but still completes.
                state_q <= S_DONE;
                done_q  <= 1'b1;
              end
            endcase
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_LOAD: begin
          state_q <= S_DONE;
          sel_q   <= SEL_HOLD;
          d_q     <= DATA_ZERO;
          done_q  <= 1'b1;
        end
        S_SHIFT: begin
          if (cnt_q == CNT_ONE) begin
            state_q <= S_DONE;
            sel_q   <= SEL_HOLD;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        S_DONE: begin
          state_q  <= S_IDLE;
          done_q   <= 1'b0;
          result_q <= gpr_q;
          cnt_q    <= CNT_ZERO;
          op_q     <= 3'd0;
        end
        default: begin
          state_q <= S_IDLE;
          sel_q   <= SEL_HOLD;
          d_q     <= DATA_ZERO;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  // Serial fill bits follow the live register contents during each shift cycle.
  always_comb begin
    l_in_s = 1'b0;
    r_in_s = 1'b0;
    if (state_q == S_SHIFT) begin
      case (op_q)
        OP_ROR:  l_in_s = gpr_q[0];
        OP_ASR:  l_in_s = gpr_q[WIDTH-1];
        OP_ROL:  r_in_s = gpr_q[WIDTH-1];
        default: begin
          l_in_s = 1'b0;
          r_in_s = 1'b0;
        end
      endcase
    end else begin
      l_in_s = 1'b0;
      r_in_s = 1'b0;
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign gpr_sel   = sel_q;
  assign gpr_d     = d_q;
  assign gpr_l_in  = l_in_s;
  assign gpr_r_in  = r_in_s;
  // The register is held during DONE, so its final value is visible in the done cycle.
  assign result    = (state_q == S_DONE) ? gpr_q : result_q;

endmodule
